// File: rtl/ysyx_22050710_arb_pkg.sv
// Shared definitions for the IF/LSU SRAM arbiter.
//   OWN_IF / OWN_LSU : response-owner and last-grant encoding
//   ARB_AW / ARB_DW  : default address / data widths
//   ARB_STARVE_LIMIT : default denied-cycle count before IF is forced through
//   REQ_IF / REQ_LSU : bit positions inside the two-bit request/grant vectors
package ysyx_22050710_arb_pkg;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int unsigned ARB_AW           = 32;
  localparam int unsigned ARB_DW           = 64;
  localparam int unsigned ARB_STARVE_LIMIT = 4;

  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_LSU = 1;

endpackage

// File: rtl/ysyx_22050710_arb_pick.sv
// Pure combinational grant selection for the two SRAM requesters.
// Configuration macro: YSYX_22050710_SRAM_ARB_RR_EN
//   defined   : round-robin, the requester that was not granted last wins a tie
//   undefined : LSU wins a tie unless starve_hit forces IF through
// Ports:
//   reqs       in  2  request vector, bit REQ_IF / bit REQ_LSU
//   starve_hit in  1  IF has been denied the limit number of cycles
//   last_gnt   in  1  owner of the most recent grant (OWN_IF / OWN_LSU)
//   gnt        out 2  one-hot (or zero) grant vector, same bit order as reqs
module ysyx_22050710_arb_pick
  import ysyx_22050710_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       starve_hit,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (reqs[REQ_IF] && reqs[REQ_LSU]) begin
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
      if (last_gnt == OWN_IF) gnt[REQ_LSU] = 1'b1;
      else                    gnt[REQ_IF]  = 1'b1;
`else
      if (starve_hit) gnt[REQ_IF]  = 1'b1;
      else            gnt[REQ_LSU] = 1'b1;
`endif
    end else begin
      // single requester (or none) passes straight through
      gnt = reqs;
    end
  end

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  logic unused_starve_hit;
  assign unused_starve_hit = starve_hit;
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/ysyx_22050710_sram_arb.sv
// Arbiter sharing one synchronous SRAM port between instruction fetch (read
// only) and the load/store unit (read/write). One grant per cycle, read data
// returned the cycle after the grant.
// Configuration macro: YSYX_22050710_SRAM_ARB_RR_EN (round-robin instead of
// fixed LSU priority with an IF starvation guard).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_if_req/i_if_addr           IF read request, held until o_if_gnt
//   o_if_gnt                     IF accepted this cycle
//   o_if_rvalid/o_if_rdata       IF read response, one cycle after grant
//   i_lsu_req/wen/addr/wdata     LSU request, held until o_lsu_gnt (wen 0 = read)
//   o_lsu_gnt                    LSU accepted this cycle
//   o_lsu_rvalid/o_lsu_rdata     LSU read response or write acknowledge (rdata 0)
//   o_sram_en/wen/addr/wdata     SRAM drive, all zero when nothing is granted
//   i_sram_rdata                 SRAM read data, valid the cycle after en
module ysyx_22050710_sram_arb
  import ysyx_22050710_arb_pkg::*;
#(
  parameter int unsigned AW           = ARB_AW,
  parameter int unsigned DW           = ARB_DW,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_lsu_req,
  input  logic [3:0]    i_lsu_wen,
  input  logic [AW-1:0] i_lsu_addr,
  input  logic [DW-1:0] i_lsu_wdata,
  output logic          o_lsu_gnt,
  output logic          o_lsu_rvalid,
  output logic [DW-1:0] o_lsu_rdata,
  output logic          o_sram_en,
  output logic [3:0]    o_sram_wen,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_wdata,
  input  logic [DW-1:0] i_sram_rdata
);

  logic [1:0] reqs;
  logic [1:0] gnt;
  logic       starve_hit;
  logic       last_gnt;

  logic       resp_vld;
  logic       resp_own;
  logic       resp_wr;

  // nothing is granted while reset is held
  assign reqs = {i_lsu_req, i_if_req} & {2{~i_rst}};

  ysyx_22050710_arb_pick u_pick (
    .reqs       (reqs),
    .starve_hit (starve_hit),
    .last_gnt   (last_gnt),
    .gnt        (gnt)
  );

  assign o_if_gnt  = gnt[REQ_IF];
  assign o_lsu_gnt = gnt[REQ_LSU];

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;

  assign starve_hit = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_gnt <= OWN_IF;
    end else if (gnt[REQ_LSU]) begin
      last_gnt <= OWN_LSU;
    end else if (gnt[REQ_IF]) begin
      last_gnt <= OWN_IF;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign starve_hit = (starve_cnt == LIMIT);
  assign last_gnt   = OWN_IF;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (i_if_req && !gnt[REQ_IF]) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_wen   = '0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (gnt[REQ_LSU]) begin
      o_sram_en    = 1'b1;
      o_sram_wen   = i_lsu_wen;
      o_sram_addr  = i_lsu_addr;
      o_sram_wdata = i_lsu_wdata;
    end else if (gnt[REQ_IF]) begin
      o_sram_en   = 1'b1;
      o_sram_addr = i_if_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_vld <= 1'b0;
      resp_own <= OWN_IF;
      resp_wr  <= 1'b0;
    end else begin
      resp_vld <= |gnt;
      resp_own <= gnt[REQ_LSU] ? OWN_LSU : OWN_IF;
      resp_wr  <= gnt[REQ_LSU] && (i_lsu_wen != 4'd0);
    end
  end

  // response is also masked by i_rst so a grant taken just before reset
  // never surfaces while reset is being asserted
  always_comb begin
    o_if_rvalid  = 1'b0;
    o_if_rdata   = '0;
    o_lsu_rvalid = 1'b0;
    o_lsu_rdata  = '0;
    if (resp_vld && !i_rst) begin
      if (resp_own == OWN_LSU) begin
        o_lsu_rvalid = 1'b1;
        o_lsu_rdata  = resp_wr ? '0 : i_sram_rdata;
      end else begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = i_sram_rdata;
      end
    end
  end

endmodule

// File: doc/ysyx_22050710_sram_arb.md
Name: ysyx_22050710_sram_arb

Overview:
- Shares the single synchronous instruction/data SRAM port between two requesters: instruction fetch (IF, read-only) and load/store unit (LSU, read/write).
- Sits between ysyx_22050710_core and ysyx_22050710_inst_sram in the top level.
- Fixed-priority arbitration with a starvation guard; grants are pipelined, one per cycle.
- Read data returns one cycle after the grant.

Parameters:
- AW, 32, address width.
- DW, 64, data width.
- STARVE_LIMIT, 4, consecutive denied IF-request cycles before IF is forced priority; range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_if_req  in  1  IF read request; held with address until grant
- i_if_addr  in  AW  IF address
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF read data valid
- o_if_rdata  out  DW  IF read data
- i_lsu_req  in  1  LSU request; held with addr/wen/wdata until grant
- i_lsu_wen  in  4  LSU write-enable; 0 means read
- i_lsu_addr  in  AW  LSU address
- i_lsu_wdata  in  DW  LSU write data
- o_lsu_gnt  out  1  LSU request accepted this cycle
- o_lsu_rvalid  out  1  LSU read data valid, or write acknowledge
- o_lsu_rdata  out  DW  LSU read data
- o_sram_en  out  1  SRAM enable
- o_sram_wen  out  4  SRAM write enable
- o_sram_addr  out  AW  SRAM address
- o_sram_wdata  out  DW  SRAM write data
- i_sram_rdata  in  DW  SRAM read data, valid the cycle after en

Behaviour:

Grant (combinational in cycle T):
- Only IF requesting: IF granted. Only LSU requesting: LSU granted.
- Both requesting: LSU granted, unless starve_cnt == STARVE_LIMIT, in which case IF is granted.
- At most one gnt is high per cycle. gnt is never high without the matching req.

SRAM drive (cycle T):
- o_sram_en = any gnt.
- Address, wen and wdata are muxed from the winner.
- When the winner is IF: o_sram_wen = 0 and o_sram_wdata = 0.
- When there is no grant: all SRAM outputs are 0.

Response (cycle T+1):
- Registers resp_vld and resp_own (0 = IF, 1 = LSU) capture the grant.
- The owner's rvalid = 1.
- The owner's rdata = i_sram_rdata, or 0 when the granted access was a write (tracked by a resp_wr register).
- The non-owner's rdata = 0.
- LSU writes receive the rvalid pulse as an acknowledge.

Pipelining:
- Back-to-back grants every cycle; no bubbles.
- A response for T and a grant for T+1 coexist.

starve_cnt (4 bits):
- Increments when IF requests and is denied.
- Clears when IF is granted or IF does not request.
- Saturates at STARVE_LIMIT.

Reset (synchronous):
- resp_vld = 0, resp_own = 0, resp_wr = 0, starve_cnt = 0.
- All rvalid and rdata = 0.
- gnt and SRAM outputs are 0 while i_rst is high.
- Reset mid-operation: an access granted in the cycle before reset produces no rvalid.

Protocol boundaries:
- Requester dropping req before gnt: the request is discarded; no response.
- A requester may issue a new req in the same cycle it receives rvalid.

Optional Feature:
- Macro: YSYX_22050710_SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_gnt register (reset value IF) selects the other requester when both request. starve_cnt is removed.
- Undefined: fixed LSU priority with the STARVE_LIMIT guard, as specified above.
- Single-requester behaviour, latency and response path are identical in both modes.

Decomposition:
- Shared package ysyx_22050710_arb_pkg holds:
  - localparams OWN_IF = 1'b0 and OWN_LSU = 1'b1;
  - the default widths AW = 32 and DW = 64;
  - the default STARVE_LIMIT.
- One sub-module, ysyx_22050710_arb_pick: pure grant logic, with inputs reqs, starve_hit and last_gnt, and a one-hot grant output. It is swapped internally by the RR macro.
- Response registers and the counter stay in the top of the block.

Test Plan:
1. IF alone reads 0x8000_0000 with the SRAM returning 0x1111_2222_3333_4444 -> if_gnt at T; if_rvalid at T+1 with that data; lsu_rvalid = 0.
2. LSU write to 0x100, wen = 0xF, wdata = 0xDEAD_BEEF -> o_sram_wen = 0xF, o_sram_addr = 0x100 at T; lsu_rvalid = 1 with rdata = 0 at T+1.
3. Both request continuously, fixed mode, STARVE_LIMIT = 4 -> LSU granted 4 cycles, IF granted the 5th, pattern repeats; IF never waits more than 4 cycles.
4. Back-to-back IF grant at T and LSU read grant at T+1 -> if_rvalid at T+1 and lsu_rvalid at T+2, each with the correct rdata; no bubble.
5. i_rst asserted the cycle after an IF grant -> no if_rvalid; all outputs 0; starve_cnt = 0 after release.
6. RR macro defined, both requesting continuously -> grants alternate starting with LSU (last_gnt reset = IF): LSU, IF, LSU, IF.
